// File: rtl/seg_595_rx.sv
// seg_595_rx: receive end of a 74HC595 serial display link (ds/shcp/stcp/oe).
// Oversamples the link in sys_clk and rebuilds each {seg,sel} frame, seg[7] first.
// It models the 595 shift/storage registers and keeps the last segment code for each digit.
//
// Ports
//   sys_clk, sys_rst_n    clock, asynchronous active-low reset
//   ds, shcp, stcp, oe    link inputs, asynchronous to sys_clk (oe active-low)
//   seg_out, sel_out      storage-register contents, blanked while oe is high
//   digit_seg             per-digit latched segment code, digit i at [8i+7:8i]
//   frame_vld/frame_err   1-cycle pulse on latch: exactly / not exactly 14 shifts
//   sel_err               1-cycle pulse on latch: sel field not one-hot
//   scan_lost             level: no latch for TIMEOUT cycles
//
// Optional feature macro SEG595_DECODE_EN: adds data_bcd, point_out and seg_unk,
// a registered decode of digit_seg (assumes SEG_W == 8).
module seg_595_rx #(
    parameter int unsigned SEL_W   = 6,
    parameter int unsigned SEG_W   = 8,
    parameter logic [19:0] TIMEOUT = 20'd999_999
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   ds,
    input  logic                   shcp,
    input  logic                   stcp,
    input  logic                   oe,
    output logic [SEG_W-1:0]       seg_out,
    output logic [SEL_W-1:0]       sel_out,
    output logic [SEL_W*SEG_W-1:0] digit_seg,
    output logic                   frame_vld,
    output logic                   frame_err,
    output logic                   sel_err,
    output logic                   scan_lost
`ifdef SEG595_DECODE_EN
    ,
    output logic [4*SEL_W-1:0]     data_bcd,
    output logic [SEL_W-1:0]       point_out,
    output logic [SEL_W-1:0]       seg_unk
`endif
);

    localparam int unsigned FRAME_W   = SEG_W + SEL_W;
    localparam logic [3:0]  FRAME_CNT = 4'(FRAME_W);
    localparam logic [3:0]  CNT_MAX   = 4'd15;

    logic [1:0]             ds_sync, oe_sync;
    logic [2:0]             shcp_sync, stcp_sync;
    logic                   ds_q, shcp_rise_q, stcp_rise_q;
    logic [FRAME_W-1:0]     shift_q, shift_d, store_q, store_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [SEL_W*SEG_W-1:0] digit_q, digit_d;
    logic                   vld_q, vld_d, ferr_q, ferr_d, serr_q, serr_d;
    logic [19:0]            tmo_q, tmo_d;
    logic [SEL_W-1:0]       lat_sel;
    logic [SEG_W-1:0]       lat_seg;
    logic                   sel_onehot;

    // Synchronisers plus one registered edge-detect stage; ds is delayed alongside shcp
    // so the shift consumes the data bit that was stable at the shcp rise.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ds_sync     <= '0;
            oe_sync     <= '0;
            shcp_sync   <= '0;
            stcp_sync   <= '0;
            ds_q        <= 1'b0;
            shcp_rise_q <= 1'b0;
            stcp_rise_q <= 1'b0;
        end else begin
            ds_sync     <= {ds_sync[0], ds};
            oe_sync     <= {oe_sync[0], oe};
            shcp_sync   <= {shcp_sync[1:0], shcp};
            stcp_sync   <= {stcp_sync[1:0], stcp};
            ds_q        <= ds_sync[1];
            shcp_rise_q <= shcp_sync[1] & ~shcp_sync[2];
            stcp_rise_q <= stcp_sync[1] & ~stcp_sync[2];
        end
    end

    // A latch always captures the pre-shift contents, so tied clocks behave like the 595.
    assign lat_sel    = shift_q[SEL_W-1:0];
    assign lat_seg    = shift_q[FRAME_W-1:SEL_W];
    assign sel_onehot = (lat_sel != '0) && ((lat_sel & (lat_sel - SEL_W'(1))) == '0);

    always_comb begin
        shift_d   = shift_q;
        store_d   = store_q;
        bit_cnt_d = bit_cnt_q;
        digit_d   = digit_q;
        vld_d     = 1'b0;
        ferr_d    = 1'b0;
        serr_d    = 1'b0;
        tmo_d     = (tmo_q == TIMEOUT) ? tmo_q : tmo_q + 20'd1;

        if (stcp_rise_q) begin
            store_d   = shift_q;
            bit_cnt_d = '0;
            tmo_d     = '0;
            if (bit_cnt_q == FRAME_CNT) begin
                vld_d = 1'b1;
            end else begin
                ferr_d = 1'b1;
            end
            if (sel_onehot) begin
                for (int unsigned i = 0; i < SEL_W; i++) begin
                    if (lat_sel[i]) begin
                        digit_d[i*SEG_W +: SEG_W] = lat_seg;
                    end
                end
            end else begin
                serr_d = 1'b1;
            end
        end

        if (shcp_rise_q) begin
            shift_d = {shift_q[FRAME_W-2:0], ds_q};
            if (stcp_rise_q) begin
                bit_cnt_d = 4'd1;
            end else if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_q   <= '0;
            store_q   <= {{SEG_W{1'b1}}, {SEL_W{1'b0}}};
            bit_cnt_q <= '0;
            digit_q   <= {(SEL_W*SEG_W){1'b1}};
            vld_q     <= 1'b0;
            ferr_q    <= 1'b0;
            serr_q    <= 1'b0;
            tmo_q     <= '0;
        end else begin
            shift_q   <= shift_d;
            store_q   <= store_d;
            bit_cnt_q <= bit_cnt_d;
            digit_q   <= digit_d;
            vld_q     <= vld_d;
            ferr_q    <= ferr_d;
            serr_q    <= serr_d;
            tmo_q     <= tmo_d;
        end
    end

    assign seg_out   = oe_sync[1] ? {SEG_W{1'b1}} : store_q[FRAME_W-1:SEL_W];
    assign sel_out   = oe_sync[1] ? {SEL_W{1'b0}} : store_q[SEL_W-1:0];
    assign digit_seg = digit_q;
    assign frame_vld = vld_q;
    assign frame_err = ferr_q;
    assign sel_err   = serr_q;
    assign scan_lost = (tmo_q == TIMEOUT);

`ifdef SEG595_DECODE_EN
    logic [4*SEL_W-1:0] bcd_d;
    logic [SEL_W-1:0]   point_d, unk_d;
    logic [7:0]         code;

    // The dp bit is forced off before lookup so a lit point does not hide the digit.
    always_comb begin
        bcd_d   = '0;
        point_d = '0;
        unk_d   = '0;
        code    = '0;
        for (int unsigned i = 0; i < SEL_W; i++) begin
            code       = digit_q[i*SEG_W +: 8] | 8'h80;
            point_d[i] = ~digit_q[i*SEG_W + 7];
            case (code)
                8'hC0:   bcd_d[i*4 +: 4] = 4'h0;
                8'hF9:   bcd_d[i*4 +: 4] = 4'h1;
                8'hA4:   bcd_d[i*4 +: 4] = 4'h2;
                8'hB0:   bcd_d[i*4 +: 4] = 4'h3;
                8'h99:   bcd_d[i*4 +: 4] = 4'h4;
                8'h92:   bcd_d[i*4 +: 4] = 4'h5;
                8'h82:   bcd_d[i*4 +: 4] = 4'h6;
                8'hF8:   bcd_d[i*4 +: 4] = 4'h7;
                8'h80:   bcd_d[i*4 +: 4] = 4'h8;
                8'h90:   bcd_d[i*4 +: 4] = 4'h9;
                8'hBF:   bcd_d[i*4 +: 4] = 4'hA;
                8'hFF:   bcd_d[i*4 +: 4] = 4'hF;
                default: begin
                    bcd_d[i*4 +: 4] = 4'hF;
                    unk_d[i]        = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_bcd  <= '0;
            point_out <= '0;
            seg_unk   <= '0;
        end else begin
            data_bcd  <= bcd_d;
            point_out <= point_d;
            seg_unk   <= unk_d;
        end
    end
`endif

endmodule

// File: tb/tb_seg_595_rx.sv
// Self-checking bench for seg_595_rx: directed scenarios plus randomized frames, all
// checked against a bit-history reference model of the 595 link.
module tb_seg_595_rx;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ds = 1'b0, shcp = 1'b0, stcp = 1'b0, oe = 1'b0;
    logic [7:0]  seg_out;
    logic [5:0]  sel_out;
    logic [47:0] digit_seg;
    logic        frame_vld, frame_err, sel_err, scan_lost;
`ifdef SEG595_DECODE_EN
    logic [23:0] data_bcd;
    logic [5:0]  point_out, seg_unk;
`endif

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    seg_595_rx #(.SEL_W(6), .SEG_W(8), .TIMEOUT(20'd100)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
        .seg_out(seg_out), .sel_out(sel_out), .digit_seg(digit_seg),
        .frame_vld(frame_vld), .frame_err(frame_err), .sel_err(sel_err),
        .scan_lost(scan_lost)
`ifdef SEG595_DECODE_EN
        , .data_bcd(data_bcd), .point_out(point_out), .seg_unk(seg_unk)
`endif
    );

    // Reference model: history of shifted bits, count since last latch, digit codes.
    bit         hist[$];
    int         since_latch;
    logic [7:0] m_digit[6];
    logic [13:0] m_store;
    bit         m_vld, m_err, m_serr;

    function automatic void m_reset();
        hist.delete();
        since_latch = 0;
        for (int i = 0; i < 6; i++) m_digit[i] = 8'hFF;
        m_store = {8'hFF, 6'h00};
    endfunction

    function automatic void m_push(bit b);
        hist.push_back(b);
        if (hist.size() > 14) void'(hist.pop_front());
        since_latch++;
    endfunction

    function automatic void m_latch();
        int unsigned f = 0;
        for (int i = 0; i < hist.size(); i++) f = f * 2 + hist[i];
        m_store = f[13:0];
        m_vld   = (since_latch == 14);
        m_err   = !m_vld;
        m_serr  = ($countones(m_store[5:0]) != 1);
        if (!m_serr)
            for (int i = 0; i < 6; i++) if (m_store[i]) m_digit[i] = m_store[13:6];
        since_latch = 0;
    endfunction

    function automatic logic [47:0] m_digits();
        logic [47:0] v;
        for (int i = 0; i < 6; i++) v[i*8 +: 8] = m_digit[i];
        return v;
    endfunction

    function automatic void m_dec(input logic [7:0] c, output logic [3:0] n, output bit unk);
        logic [7:0] tbl[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        logic [7:0] k = c | 8'h80;
        n = 4'hF;
        unk = (k != 8'hFF) && (k != 8'hBF);
        if (k == 8'hBF) n = 4'hA;
        for (int i = 0; i < 10; i++) if (tbl[i] == k) begin n = 4'(i); unk = 0; end
    endfunction

    task automatic send_bit(input bit b);
        @(negedge clk) ds = b;
        @(negedge clk) shcp = 1'b1;
        repeat (2) @(negedge clk);
        shcp = 1'b0;
        @(negedge clk);
        m_push(b);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Raises stcp (optionally with shcp in the same cycle) and samples {vld,err,serr}
    // after the third and fourth sys_clk edges that see stcp high.
    task automatic latch(input bit tied, input bit b, output logic [2:0] pre,
                         output logic [2:0] post);
        @(negedge clk) ds = b;
        @(negedge clk) begin stcp = 1'b1; shcp = tied; end
        repeat (3) @(posedge clk);
        #1 pre = {frame_vld, frame_err, sel_err};
        @(posedge clk);
        #1 post = {frame_vld, frame_err, sel_err};
        m_latch();
        if (tied) begin m_push(b); since_latch = 1; end
        @(negedge clk) begin stcp = 1'b0; shcp = 1'b0; end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (seg_out !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h exp=ff", seg_out); end
        total++; if (sel_out !== 6'h00) begin bad++; $display("FAIL reset_sel got=%h exp=00", sel_out); end
        total++; if (digit_seg !== {48{1'b1}}) begin bad++; $display("FAIL reset_digit got=%h", digit_seg); end
        total++; if ({frame_vld, frame_err, sel_err, scan_lost} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {frame_vld, frame_err, sel_err, scan_lost}); end
        rst_n = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [2:0] pre, post;
        send_bits({8'hC0, 6'b000001}, 14);
        latch(0, 0, pre, post);
        total++; if (pre !== 3'b000) begin bad++; $display("FAIL basic_early got=%b exp=000", pre); end
        total++; if (post !== 3'b100) begin bad++; $display("FAIL basic_pulse got=%b exp=100", post); end
        total++; if ({seg_out, sel_out} !== {8'hC0, 6'h01}) begin
            bad++; $display("FAIL basic_store got=%h/%h exp=c0/01", seg_out, sel_out); end
        total++; if (digit_seg !== {40'hFF_FFFF_FFFF, 8'hC0}) begin
            bad++; $display("FAIL basic_digit got=%h", digit_seg); end
        total++; if (frame_vld !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=1 exp=0"); end
    endtask

    task automatic test_count();
        logic [2:0] pre, post;
        send_bits({8'h82, 6'b000010}, 13);
        latch(0, 0, pre, post);
        total++; if (post[2:1] !== 2'b01) begin bad++; $display("FAIL short_pulse got=%b exp=01", post[2:1]); end
        total++; if (post !== {m_vld, m_err, m_serr}) begin
            bad++; $display("FAIL short_model got=%b exp=%b", post, {m_vld, m_err, m_serr}); end
        total++; if ({seg_out, sel_out} !== m_store) begin
            bad++; $display("FAIL short_store got=%h exp=%h", {seg_out, sel_out}, m_store); end
        send_bit(1'b1);
        send_bits({8'hF9, 6'b000100}, 14);
        latch(0, 0, pre, post);
        total++; if (post !== 3'b010) begin bad++; $display("FAIL long_pulse got=%b exp=010", post); end
        total++; if ({seg_out, sel_out} !== {8'hF9, 6'h04}) begin
            bad++; $display("FAIL long_store got=%h/%h exp=f9/04", seg_out, sel_out); end
        total++; if (digit_seg !== m_digits()) begin
            bad++; $display("FAIL long_digit got=%h exp=%h", digit_seg, m_digits()); end
    endtask

    task automatic test_sel_err();
        logic [2:0] pre, post;
        send_bits({8'h99, 6'b000011}, 14);
        latch(0, 0, pre, post);
        total++; if (post !== 3'b101) begin bad++; $display("FAIL selerr_two got=%b exp=101", post); end
        total++; if (digit_seg !== m_digits()) begin
            bad++; $display("FAIL selerr_digit got=%h exp=%h", digit_seg, m_digits()); end
        send_bits({8'h99, 6'b000000}, 14);
        latch(0, 0, pre, post);
        total++; if (post !== 3'b101) begin bad++; $display("FAIL selerr_zero got=%b exp=101", post); end
        total++; if (digit_seg !== m_digits()) begin
            bad++; $display("FAIL selerr_digit0 got=%h exp=%h", digit_seg, m_digits()); end
    endtask

    task automatic test_oe();
        logic [2:0] pre, post;
        send_bits({8'hA4, 6'b001000}, 14);
        latch(0, 0, pre, post);
        @(negedge clk) oe = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({seg_out, sel_out} !== {8'hFF, 6'h00}) begin
            bad++; $display("FAIL oe_blank got=%h/%h exp=ff/00", seg_out, sel_out); end
        total++; if (digit_seg !== m_digits()) begin
            bad++; $display("FAIL oe_digit got=%h exp=%h", digit_seg, m_digits()); end
        @(negedge clk) oe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({seg_out, sel_out} !== {8'hA4, 6'h08}) begin
            bad++; $display("FAIL oe_restore got=%h/%h exp=a4/08", seg_out, sel_out); end
    endtask

    task automatic test_tied();
        logic [2:0] pre, post;
        logic [13:0] y = {8'hB0, 6'b100000};
        send_bits({8'h92, 6'b010000}, 14);
        latch(1, y[13], pre, post);
        total++; if (post !== 3'b100) begin bad++; $display("FAIL tied_pulse got=%b exp=100", post); end
        total++; if ({seg_out, sel_out} !== {8'h92, 6'h10}) begin
            bad++; $display("FAIL tied_store got=%h/%h exp=92/10", seg_out, sel_out); end
        send_bits({18'h0, y}, 13);
        latch(0, 0, pre, post);
        total++; if (post !== 3'b100) begin bad++; $display("FAIL tied_next got=%b exp=100", post); end
        total++; if ({seg_out, sel_out} !== y) begin
            bad++; $display("FAIL tied_next_store got=%h exp=%h", {seg_out, sel_out}, y); end
    endtask

    task automatic test_random();
        int ncs[5] = '{13, 14, 14, 15, 16};
        logic [2:0] pre, post;
        for (int it = 0; it < 12; it++) begin
            logic [7:0] sg = 8'($urandom);
            logic [5:0] sl = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                                          : 6'(1 << $urandom_range(0, 5));
            int n = ncs[$urandom_range(0, 4)];
            if (n >= 14) begin
                send_bits($urandom, n - 14);
                send_bits({18'h0, sg, sl}, 14);
            end else begin
                send_bits({18'h0, sg, sl}, n);
            end
            latch(0, 0, pre, post);
            total++; if (post !== {m_vld, m_err, m_serr}) begin
                bad++; $display("FAIL rand_pulse it=%0d got=%b exp=%b", it, post, {m_vld, m_err, m_serr}); end
            total++; if ({seg_out, sel_out} !== m_store) begin
                bad++; $display("FAIL rand_store it=%0d got=%h exp=%h", it, {seg_out, sel_out}, m_store); end
            total++; if (digit_seg !== m_digits()) begin
                bad++; $display("FAIL rand_digit it=%0d got=%h exp=%h", it, digit_seg, m_digits()); end
`ifdef SEG595_DECODE_EN
            begin
                logic [23:0] eb;
                logic [5:0]  eu, ep;
                for (int i = 0; i < 6; i++) begin
                    logic [3:0] nn;
                    bit uu;
                    m_dec(m_digit[i], nn, uu);
                    eb[i*4 +: 4] = nn;
                    eu[i] = uu;
                    ep[i] = ~m_digit[i][7];
                end
                total++; if ({data_bcd, seg_unk, point_out} !== {eb, eu, ep}) begin
                    bad++; $display("FAIL rand_decode it=%0d got=%h/%b/%b exp=%h/%b/%b",
                                    it, data_bcd, seg_unk, point_out, eb, eu, ep); end
            end
`endif
        end
    endtask

    task automatic test_timeout();
        send_bits({8'hB0, 6'b010000}, 14);
        @(negedge clk) stcp = 1'b1;
        repeat (4) @(posedge clk);
        #1 stcp = 1'b0;
        m_latch();
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k == 99) begin
                total++; if (scan_lost !== 1'b0) begin bad++; $display("FAIL tmo_early got=1 exp=0"); end
            end
            if (k == 100) begin
                total++; if (scan_lost !== 1'b1) begin bad++; $display("FAIL tmo_set got=0 exp=1"); end
            end
        end
        @(negedge clk) stcp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (scan_lost !== 1'b1) begin bad++; $display("FAIL tmo_hold got=0 exp=1"); end
        @(posedge clk);
        #1;
        total++; if (scan_lost !== 1'b0) begin bad++; $display("FAIL tmo_clear got=1 exp=0"); end
        m_latch();
        @(negedge clk) stcp = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef SEG595_DECODE_EN
    task automatic test_decode();
        logic [7:0] codes[6] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h12};
        logic [2:0] pre, post;
        for (int i = 0; i < 6; i++) begin
            send_bits({18'h0, codes[i], 6'(1 << i)}, 14);
            latch(0, 0, pre, post);
        end
        total++; if (data_bcd !== 24'h543210) begin bad++; $display("FAIL dec_bcd got=%h exp=543210", data_bcd); end
        total++; if (point_out !== 6'b100000) begin bad++; $display("FAIL dec_point got=%b exp=100000", point_out); end
        total++; if (seg_unk !== 6'b0) begin bad++; $display("FAIL dec_unk0 got=%b exp=000000", seg_unk); end
        send_bits({18'h0, 8'hAA, 6'b000001}, 14);
        latch(0, 0, pre, post);
        total++; if (seg_unk !== 6'b000001) begin bad++; $display("FAIL dec_unk got=%b exp=000001", seg_unk); end
        total++; if (data_bcd !== 24'h54321F) begin bad++; $display("FAIL dec_unk_bcd got=%h exp=54321f", data_bcd); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [2:0] pre, post;
        send_bits({8'h80, 6'b000100}, 7);
        @(negedge clk) ds = 1'b1;
        @(negedge clk) shcp = 1'b1;
        @(negedge clk) rst_n = 1'b0;
        #1;
        total++; if ({seg_out, sel_out} !== {8'hFF, 6'h00}) begin
            bad++; $display("FAIL rmid_store got=%h/%h exp=ff/00", seg_out, sel_out); end
        total++; if (digit_seg !== {48{1'b1}}) begin bad++; $display("FAIL rmid_digit got=%h", digit_seg); end
        total++; if ({frame_vld, frame_err, sel_err, scan_lost} !== 4'b0) begin
            bad++; $display("FAIL rmid_flags got=%b exp=0000", {frame_vld, frame_err, sel_err, scan_lost}); end
`ifdef SEG595_DECODE_EN
        total++; if ({data_bcd, point_out, seg_unk} !== 36'h0) begin
            bad++; $display("FAIL rmid_decode got=%h exp=0", {data_bcd, point_out, seg_unk}); end
`endif
        shcp = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_bits({8'h90, 6'b100000}, 5);
        latch(0, 0, pre, post);
        total++; if (post[2:1] !== 2'b01) begin bad++; $display("FAIL rmid_err got=%b exp=01", post[2:1]); end
        total++; if ({seg_out, sel_out} !== m_store) begin
            bad++; $display("FAIL rmid_after got=%h exp=%h", {seg_out, sel_out}, m_store); end
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_count();
        test_sel_err();
        test_oe();
        test_tied();
        test_random();
        test_timeout();
`ifdef SEG595_DECODE_EN
        test_decode();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
